// File: rtl/quad_decoder_counter.sv
// Quadrature encoder front end: synchroniser, per-line de-glitch filter, x4/x2/x1
// Gray-code decoder and wrapping signed position counter with direction/step/err.
module quad_decoder_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] pos,
  output logic [1:0]       dir,
  output logic             step,
  output logic             err
);

  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;
  localparam int IC_W = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] sync_a_r;
  logic [SYNC_STAGES-1:0] sync_b_r;
  logic [1:0]             sync_out_s;
  logic [1:0]             filt_r;
  logic [1:0]             prev_r;
  logic [FC_W-1:0]        fcnt_r [2];
  logic [IC_W-1:0]        init_cnt_r;
  logic                   init_done_s;
  logic [1:0]             diff_s;
  logic                   cw_s;
  logic                   ccw_s;
  logic                   illegal_s;
  logic                   counted_s;
  logic                   count_ok_s;

  // Gray {A,B} to quadrature phase index: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign sync_out_s  = {sync_a_r[SYNC_STAGES-1], sync_b_r[SYNC_STAGES-1]};
  assign init_done_s = (init_cnt_r == IC_W'(SYNC_STAGES + 1));

  // Input synchronisers for the asynchronous encoder pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_r <= '0;
      sync_b_r <= '0;
    end else begin
      sync_a_r <= {sync_a_r[SYNC_STAGES-2:0], a};
      sync_b_r <= {sync_b_r[SYNC_STAGES-2:0], b};
    end
  end

  // Per-line stability filter; during init the filtered level follows the sync output.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_r     <= 2'b00;
      init_cnt_r <= '0;
      for (int i = 0; i < 2; i++) fcnt_r[i] <= '0;
    end else begin
      if (!init_done_s) begin
        init_cnt_r <= init_cnt_r + 1'b1;
      end else begin
        init_cnt_r <= init_cnt_r;
      end
      for (int i = 0; i < 2; i++) begin
        if (!init_done_s) begin
          filt_r[i] <= sync_out_s[i];
          fcnt_r[i] <= '0;
        end else if (sync_out_s[i] != filt_r[i]) begin
          if (fcnt_r[i] == FC_W'(FILT_LEN - 1)) begin
            filt_r[i] <= sync_out_s[i];
            fcnt_r[i] <= '0;
          end else begin
            fcnt_r[i] <= fcnt_r[i] + 1'b1;
          end
        end else begin
          fcnt_r[i] <= '0;
        end
      end
    end
  end

  // Transition classification between previous and current filtered state.
  always_comb begin
    diff_s    = gray2bin(filt_r) - gray2bin(prev_r);
    cw_s      = (diff_s == 2'b01);
    ccw_s     = (diff_s == 2'b11);
    illegal_s = (diff_s == 2'b10) && init_done_s;
    case (mode)
      2'b01:   counted_s = (filt_r[1] != prev_r[1]);
      2'b10:   counted_s = ((prev_r == 2'b01) && (filt_r == 2'b11)) ||
                           ((prev_r == 2'b11) && (filt_r == 2'b01));
      default: counted_s = 1'b1;
    endcase
    if (init_done_s && en && (cw_s || ccw_s)) begin
      count_ok_s = counted_s;
    end else begin
      count_ok_s = 1'b0;
    end
  end

  // Position, direction, step strobe and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= 2'b00;
      pos    <= '0;
      dir    <= 2'b00;
      step   <= 1'b0;
      err    <= 1'b0;
    end else begin
      prev_r <= init_done_s ? filt_r : sync_out_s;
      step   <= 1'b0;
      if (clr) begin
        pos <= '0;
        dir <= 2'b00;
      end else if (count_ok_s) begin
        step <= 1'b1;
        if (cw_s) begin
          pos <= pos + {{(CNT_W-1){1'b0}}, 1'b1};
          dir <= 2'b01;
        end else begin
          pos <= pos - {{(CNT_W-1){1'b0}}, 1'b1};
          dir <= 2'b10;
        end
      end else begin
        pos <= pos;
        dir <= dir;
      end
      // A new illegal transition wins over a simultaneous clear request.
      if (err_clr) begin
        err <= illegal_s && en;
      end else if (illegal_s && en) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
    end
  end

endmodule
